// File: rtl/mmu_sequencer_if.sv
// Operand-load and run-control bundle between a host and mmu_sequencer.
// slave = sequencer side, master = host side.
interface mmu_sequencer_if #(
   parameter int WIDTH  = 8,
   parameter int LENGTH = 3
);
   localparam int RW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

   // Wr_En is taken on a rising edge only while Busy=0 and no run is pending;
   // Start is taken only while the sequencer is idle or showing Done.
   logic                      Wr_En;
   logic                      Wr_Sel;
   logic [RW-1:0]             Wr_Row;
   logic [LENGTH*WIDTH-1:0]   Wr_Data;
   logic                      Start;
   logic                      Hold;
   logic                      Busy;
   logic                      Done;
   logic                      MMU_EN;
   logic                      MMU_SYNC_RST;
   logic [LENGTH*WIDTH-1:0]   MMU_Inputs;
   logic [LENGTH*WIDTH-1:0]   MMU_Weights;

   modport slave (
      input  Wr_En, Wr_Sel, Wr_Row, Wr_Data, Start, Hold,
      output Busy, Done, MMU_EN, MMU_SYNC_RST, MMU_Inputs, MMU_Weights
   );

   modport master (
      output Wr_En, Wr_Sel, Wr_Row, Wr_Data, Start, Hold,
      input  Busy, Done, MMU_EN, MMU_SYNC_RST, MMU_Inputs, MMU_Weights
   );
endinterface

// File: rtl/mmu_sequencer.sv
// Feeds one LENGTH x LENGTH tile into a systolic multiply unit with diagonal skew.
// Define MMU_SEQ_AUTO_CLEAR_EN to insert a CLEAR cycle that resets the unit before each run.
module mmu_sequencer #(
   parameter int WIDTH        = 8,
   parameter int LENGTH       = 3,
   parameter int DRAIN_CYCLES = LENGTH
) (
   input  logic                 CLK,
   input  logic                 ASYNC_RST,
   mmu_sequencer_if.slave       bus,
   output logic [2:0]           state_dbg
);
   localparam int LW = LENGTH * WIDTH;
   localparam int CW = $clog2(2 * LENGTH + DRAIN_CYCLES + 1);
   localparam logic [CW-1:0] FEED_LAST  = CW'(2 * LENGTH - 2);
   localparam logic [CW-1:0] DRAIN_LAST = CW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [LW-1:0]   a_q [LENGTH];
   logic [LW-1:0]   a_d [LENGTH];
   logic [LW-1:0]   b_q [LENGTH];
   logic [LW-1:0]   b_d [LENGTH];
   logic            busy_q, busy_d, done_q, done_d, en_q, en_d, srst_q, srst_d;
   logic [LW-1:0]   inp_q, inp_d, wgt_q, wgt_d;
   logic            hold_act, wr_ok;

   assign hold_act = bus.Hold && (state_q == S_FEED || state_q == S_DRAIN);
   assign wr_ok    = bus.Wr_En && !busy_q && (state_q == S_IDLE || state_q == S_DONE);

   always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (bus.Start) begin
               cnt_d = '0;
`ifdef MMU_SEQ_AUTO_CLEAR_EN
               state_d = S_CLEAR;
`else
               state_d = S_FEED;
`endif
            end
         end
         S_CLEAR: begin
            state_d = S_FEED;
            cnt_d   = '0;
         end
         S_FEED: begin
            if (!hold_act) begin
               if (cnt_q == FEED_LAST) begin
                  cnt_d   = '0;
                  state_d = (DRAIN_CYCLES > 0) ? S_DRAIN : S_DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (!hold_act) begin
               if (cnt_q == DRAIN_LAST) begin
                  cnt_d   = '0;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the current state and registered, so they trail the state by one edge.
   always_comb begin
      inp_d  = inp_q;
      wgt_d  = wgt_q;
      busy_d = 1'b0;
      done_d = 1'b0;
      en_d   = 1'b0;
      srst_d = 1'b0;
      case (state_q)
         S_CLEAR: begin
            busy_d = 1'b1;
            en_d   = 1'b1;
            srst_d = 1'b1;
            inp_d  = '0;
            wgt_d  = '0;
         end
         S_FEED: begin
            busy_d = 1'b1;
            if (!hold_act) begin
               en_d = 1'b1;
               for (int i = 0; i < LENGTH; i++) begin
                  inp_d[i*WIDTH +: WIDTH] = '0;
                  wgt_d[i*WIDTH +: WIDTH] = '0;
                  for (int k = 0; k < LENGTH; k++) begin
                     if (int'(cnt_q) == i + k) begin
                        inp_d[i*WIDTH +: WIDTH] = a_q[i][k*WIDTH +: WIDTH];
                        wgt_d[i*WIDTH +: WIDTH] = b_q[k][i*WIDTH +: WIDTH];
                     end
                  end
               end
            end
         end
         S_DRAIN: begin
            busy_d = 1'b1;
            if (!hold_act) begin
               en_d  = 1'b1;
               inp_d = '0;
               wgt_d = '0;
            end
         end
         S_DONE: begin
            done_d = 1'b1;
            inp_d  = '0;
            wgt_d  = '0;
         end
         default: begin
            inp_d = '0;
            wgt_d = '0;
         end
      endcase
   end

   always_comb begin
      for (int r = 0; r < LENGTH; r++) begin
         a_d[r] = a_q[r];
         b_d[r] = b_q[r];
         if (wr_ok && int'(bus.Wr_Row) == r) begin
            if (bus.Wr_Sel) b_d[r] = bus.Wr_Data;
            else            a_d[r] = bus.Wr_Data;
         end
      end
   end

   always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST) begin
         for (int r = 0; r < LENGTH; r++) begin
            a_q[r] <= '0;
            b_q[r] <= '0;
         end
         busy_q <= 1'b0;
         done_q <= 1'b0;
         en_q   <= 1'b0;
         srst_q <= 1'b0;
         inp_q  <= '0;
         wgt_q  <= '0;
      end else begin
         for (int r = 0; r < LENGTH; r++) begin
            a_q[r] <= a_d[r];
            b_q[r] <= b_d[r];
         end
         busy_q <= busy_d;
         done_q <= done_d;
         en_q   <= en_d;
         srst_q <= srst_d;
         inp_q  <= inp_d;
         wgt_q  <= wgt_d;
      end
   end

   assign bus.Busy        = busy_q;
   assign bus.Done        = done_q;
   assign bus.MMU_EN      = en_q;
   assign bus.MMU_Inputs  = inp_q;
   assign bus.MMU_Weights = wgt_q;
`ifdef MMU_SEQ_AUTO_CLEAR_EN
   assign bus.MMU_SYNC_RST = srst_q;
`else
   // Without the CLEAR state the multiply unit keeps accumulating across runs.
   assign bus.MMU_SYNC_RST = 1'b0;
`endif
   assign state_dbg = state_q;
endmodule

// File: tb/tb_mmu_sequencer.sv
// Bench for mmu_sequencer: frame-queue reference model checked every cycle,
// plus literal operand streams, tile products, latencies and reset behaviour.
module tb_mmu_sequencer;
   localparam int W  = 8;
   localparam int L  = 3;
   localparam int D  = L;
   localparam int LW = L * W;
`ifdef MMU_SEQ_AUTO_CLEAR_EN
   localparam int CLR = 1;
   localparam int LAT_LIT = 10;
   localparam int MULT2 = 1;
`else
   localparam int CLR = 0;
   localparam int LAT_LIT = 9;
   localparam int MULT2 = 2;
`endif

   typedef struct packed {
      logic          busy;
      logic          done;
      logic          en;
      logic          srst;
      logic          stall_ok;
      logic [LW-1:0] inp;
      logic [LW-1:0] wgt;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] state_dbg;

   mmu_sequencer_if #(.WIDTH(W), .LENGTH(L)) bus ();

   mmu_sequencer #(.WIDTH(W), .LENGTH(L), .DRAIN_CYCLES(D)) dut (
      .CLK       (clk),
      .ASYNC_RST (rst_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int done_seen = 0;
   logic [W-1:0]  ma [L][L];
   logic [W-1:0]  mb [L][L];
   frame_t        nq[$];
   frame_t        exp_cur;
   logic [LW-1:0] obs_inp[$];
   logic [LW-1:0] obs_wgt[$];

   int a_dir [L][L] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
   int b_dir [L][L] = '{'{1, 2, 1}, '{2, 4, 6}, '{7, 2, 5}};
   int r_dir [L][L] = '{'{26, 16, 28}, '{56, 40, 64}, '{86, 64, 100}};
   int lit_i [5][L] = '{'{1, 0, 0}, '{2, 4, 0}, '{3, 5, 7}, '{0, 6, 8}, '{0, 0, 9}};
   int lit_w [5][L] = '{'{1, 0, 0}, '{2, 2, 0}, '{7, 4, 1}, '{0, 2, 6}, '{0, 0, 5}};

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] elem(input logic [LW-1:0] v, input int k);
      return v[k*W +: W];
   endfunction

   function automatic logic [LW-1:0] pack_row(input int e[L]);
      logic [LW-1:0] v;
      v = '0;
      for (int k = 0; k < L; k++) v[k*W +: W] = W'(e[k]);
      return v;
   endfunction

   // Output-stationary array: PE(i,j) sees row i delayed by j and column j delayed by i.
   function automatic int res(input int i, input int j);
      int s;
      s = 0;
      for (int n = 0; n < obs_inp.size(); n++)
         if (n - j >= 0 && n - i >= 0)
            s += int'(elem(obs_inp[n-j], i)) * int'(elem(obs_wgt[n-i], j));
      return s;
   endfunction

   task automatic model_reset();
      nq.delete();
      exp_cur = '0;
      for (int i = 0; i < L; i++)
         for (int j = 0; j < L; j++) begin
            ma[i][j] = '0;
            mb[i][j] = '0;
         end
   endtask

   // Expected outputs of one run, one frame per unstalled edge after the accepting edge.
   task automatic build_run();
      frame_t f;
      if (CLR == 1) begin
         f = '0; f.busy = 1'b1; f.en = 1'b1; f.srst = 1'b1;
         nq.push_back(f);
      end
      for (int t = 0; t < 2*L-1; t++) begin
         f = '0; f.busy = 1'b1; f.en = 1'b1; f.stall_ok = 1'b1;
         for (int i = 0; i < L; i++)
            if (t - i >= 0 && t - i < L) begin
               f.inp[i*W +: W] = ma[i][t-i];
               f.wgt[i*W +: W] = mb[t-i][i];
            end
         nq.push_back(f);
      end
      for (int d = 0; d < D; d++) begin
         f = '0; f.busy = 1'b1; f.en = 1'b1; f.stall_ok = 1'b1;
         nq.push_back(f);
      end
      f = '0; f.done = 1'b1;
      nq.push_back(f);
   endtask

   task automatic model_edge();
      frame_t nxt;
      logic   acc;
      int     row;
      if (!rst_n) begin
         model_reset();
         return;
      end
      acc = (nq.size() == 0) || nq[0].done;
      row = int'(bus.Wr_Row);
      if (bus.Wr_En && acc && !exp_cur.busy && row < L)
         for (int k = 0; k < L; k++) begin
            if (bus.Wr_Sel) mb[row][k] = elem(bus.Wr_Data, k);
            else            ma[row][k] = elem(bus.Wr_Data, k);
         end
      if (nq.size() == 0) nxt = '0;
      else if (nq[0].stall_ok && bus.Hold) begin
         nxt = exp_cur;
         nxt.busy = 1'b1; nxt.done = 1'b0; nxt.en = 1'b0; nxt.srst = 1'b0; nxt.stall_ok = 1'b0;
      end else nxt = nq.pop_front();
      if (bus.Start && acc) build_run();
      exp_cur = nxt;
   endtask

   task automatic compare_all();
      check("busy",    64'(bus.Busy),         64'(exp_cur.busy));
      check("done",    64'(bus.Done),         64'(exp_cur.done));
      check("mmu_en",  64'(bus.MMU_EN),       64'(exp_cur.en));
      check("sync_rst",64'(bus.MMU_SYNC_RST), 64'(exp_cur.srst));
      check("inputs",  64'(bus.MMU_Inputs),   64'(exp_cur.inp));
      check("weights", 64'(bus.MMU_Weights),  64'(exp_cur.wgt));
      if (bus.Done === 1'b1) done_seen++;
      if (bus.MMU_EN === 1'b1) begin
         if (bus.MMU_SYNC_RST === 1'b1) begin
            obs_inp.delete();
            obs_wgt.delete();
         end else begin
            obs_inp.push_back(bus.MMU_Inputs);
            obs_wgt.push_back(bus.MMU_Weights);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic drive_idle();
      bus.Start = 1'b0; bus.Hold = 1'b0; bus.Wr_En = 1'b0;
      bus.Wr_Sel = 1'b0; bus.Wr_Row = '0; bus.Wr_Data = '0;
   endtask

   task automatic write_row(input logic sel, input int row, input logic [LW-1:0] data);
      bus.Wr_En = 1'b1; bus.Wr_Sel = sel; bus.Wr_Row = 2'(row); bus.Wr_Data = data;
      tick();
      bus.Wr_En = 1'b0;
   endtask

   task automatic obs_clear();
      obs_inp.delete();
      obs_wgt.delete();
   endtask

   task automatic run(input int hold_at, input int hold_len, input bit poke, output int lat);
      done_seen = 0;
      lat = -1;
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      for (int k = 1; k < 60 && lat < 0; k++) begin
         bus.Hold = (k >= hold_at && k < hold_at + hold_len);
         if (poke && k == 4) begin
            bus.Start = 1'b1; bus.Wr_En = 1'b1; bus.Wr_Sel = 1'b0;
            bus.Wr_Row = '0; bus.Wr_Data = '1;
         end
         tick();
         drive_idle();
         if (bus.Done === 1'b1) lat = k;
      end
      check("done_pulses", 64'(done_seen), 64'd1);
   endtask

   task automatic check_result(input string name, input int mult);
      for (int i = 0; i < L; i++)
         for (int j = 0; j < L; j++)
            check(name, 64'(res(i, j)), 64'(r_dir[i][j] * mult));
   endtask

   initial begin
      int lat, lat2;
      drive_idle();
      model_reset();
      repeat (3) tick();
      check("reset_outputs", 64'({bus.Busy, bus.Done, bus.MMU_EN, bus.MMU_SYNC_RST,
                                  bus.MMU_Inputs, bus.MMU_Weights}), 64'd0);
      rst_n = 1'b1;

      for (int r = 0; r < L; r++) begin
         write_row(1'b0, r, pack_row(a_dir[r]));
         write_row(1'b1, r, pack_row(b_dir[r]));
      end
      write_row(1'b0, 3, '1);

      // Directed tile: literal skewed operand stream and product.
      obs_clear();
      run(0, 0, 1'b0, lat);
      check("latency", 64'(lat), 64'(LAT_LIT));
      check("feed_len", 64'(obs_inp.size()), 64'd8);
      for (int t = 0; t < 5 && t < obs_inp.size(); t++) begin
         check("lit_inputs",  64'(obs_inp[t]), 64'(pack_row(lit_i[t])));
         check("lit_weights", 64'(obs_wgt[t]), 64'(pack_row(lit_w[t])));
      end
      check_result("result", 1);

      // Three-cycle hold at feed step 2.
      obs_clear();
      run(3 + CLR, 3, 1'b0, lat);
      check("hold_latency", 64'(lat), 64'(LAT_LIT + 3));
      check("hold_feed_len", 64'(obs_inp.size()), 64'd8);
      check_result("hold_result", 1);

      // Start and write attempts while busy must be dropped.
      obs_clear();
      run(0, 0, 1'b1, lat);
      check("poke_latency", 64'(lat), 64'(LAT_LIT));
      check_result("poke_result", 1);

      // Back-to-back runs: multiply unit cleared only with the CLEAR state present.
      obs_clear();
      run(0, 0, 1'b0, lat);
      run(0, 0, 1'b0, lat2);
      check("b2b_latency", 64'(lat2), 64'(LAT_LIT));
      check_result("b2b_result", MULT2);

      // Reset during DRAIN: immediate zero outputs, no Done, buffers cleared.
      done_seen = 0;
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      for (int k = 1; k <= 8; k++) tick();
      check("abort_busy_before", 64'(bus.Busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort_outputs", 64'({bus.Busy, bus.Done, bus.MMU_EN, bus.MMU_SYNC_RST,
                                  bus.MMU_Inputs, bus.MMU_Weights}), 64'd0);
      model_reset();
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check("abort_no_done", 64'(done_seen), 64'd0);
      obs_clear();
      run(0, 0, 1'b0, lat);
      check("post_reset_latency", 64'(lat), 64'(LAT_LIT));
      for (int i = 0; i < L; i++)
         for (int j = 0; j < L; j++)
            check("post_reset_zero", 64'(res(i, j)), 64'd0);

      // Randomised traffic against the frame model.
      for (int c = 0; c < 1500; c++) begin
         bus.Start   = ($urandom_range(0, 7) == 0);
         bus.Hold    = ($urandom_range(0, 3) == 0);
         bus.Wr_En   = ($urandom_range(0, 2) == 0);
         bus.Wr_Sel  = 1'($urandom_range(0, 1));
         bus.Wr_Row  = 2'($urandom_range(0, 3));
         bus.Wr_Data = LW'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            rst_n = 1'b0;
            #1;
            check("rand_async_reset", 64'({bus.Busy, bus.Done, bus.MMU_EN,
                                           bus.MMU_Inputs, bus.MMU_Weights}), 64'd0);
            model_reset();
            tick();
            rst_n = 1'b1;
         end else begin
            tick();
         end
      end
      drive_idle();
      repeat (20) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
